// File: rtl/flip_ctrl.sv
// Flipper command controller: per-side button synchronizer, debouncer and
// stroke FSM with hold-time limit and forced cooldown for coil protection.
//
// state        | meaning
// -------------+----------------------------------------------------------
// IDLE         | flipper down, waiting for a debounced press with en high
// ACTIVE       | flipper raised; hold time measured by the phase counter
// COOLDOWN     | forced low after a hold timeout; ignores en and button
// WAIT_RELEASE | flipper down until the button is released with en high
module flip_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_HOLD_CYCLES = 100000000,
    parameter int unsigned COOLDOWN_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic        move_left_flip,
    output logic        move_right_flip,
    output logic        timeout_left,
    output logic        timeout_right,
    output logic [15:0] strokes_left,
    output logic [15:0] strokes_right
);

    localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(MAX_HOLD_CYCLES - 1);
    localparam logic [31:0] COOL_LAST = 32'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ACTIVE       = 2'd1,
        COOLDOWN     = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    logic [1:0] btn;
    assign btn = {btn_right, btn_left};

    for (genvar s = 0; s < 2; s++) begin : g_side
        logic        sync1;
        logic        sync2;
        logic        deb;
        logic [31:0] deb_cnt;
        logic [31:0] phase;
        state_t      state;
        logic        move;
        logic        timeout;
        logic [15:0] strokes;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= btn[s];
                sync2 <= sync1;
            end
        end

        // Any cycle where the synchronized level agrees with deb restarts the run.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                deb     <= 1'b0;
                deb_cnt <= '0;
            end else if (sync2 != deb) begin
                if (deb_cnt == DEB_LAST) begin
                    deb     <= sync2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 32'd1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= IDLE;
                phase   <= '0;
                move    <= 1'b0;
                timeout <= 1'b0;
                strokes <= '0;
            end else begin
                timeout <= 1'b0;
                case (state)
                    IDLE: begin
                        if (deb && en) begin
                            state <= ACTIVE;
                            phase <= '0;
                            move  <= 1'b1;
                            if (strokes != 16'hFFFF) begin
                                strokes <= strokes + 16'd1;
                            end
                        end
                    end
                    ACTIVE: begin
                        phase <= phase + 32'd1;
                        // Release wins over both tilt and timeout.
                        if (!deb) begin
                            state <= IDLE;
                            phase <= '0;
                            move  <= 1'b0;
                        end else if (!en) begin
                            state <= WAIT_RELEASE;
                            phase <= '0;
                            move  <= 1'b0;
                        end else if (phase == HOLD_LAST) begin
                            state   <= COOLDOWN;
                            phase   <= '0;
                            move    <= 1'b0;
                            timeout <= 1'b1;
                        end
                    end
                    COOLDOWN: begin
                        phase <= phase + 32'd1;
                        if (phase == COOL_LAST) begin
                            state <= WAIT_RELEASE;
                            phase <= '0;
                        end
                    end
                    WAIT_RELEASE: begin
                        if (!deb && en) begin
                            state <= IDLE;
                            phase <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        phase <= '0;
                        move  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign move_left_flip  = g_side[0].move;
    assign move_right_flip = g_side[1].move;
    assign timeout_left    = g_side[0].timeout;
    assign timeout_right   = g_side[1].timeout;
    assign strokes_left    = g_side[0].strokes;
    assign strokes_right   = g_side[1].strokes;

endmodule

// File: tb/tb_flip_ctrl.sv
// Bench for flip_ctrl: directed scenarios plus random button/enable traffic,
// every cycle compared against a cycle-counting behavioural model.
module tb_flip_ctrl;

    localparam int D    = 4;
    localparam int MAXH = 20;
    localparam int COOL = 8;

    logic        clk;
    logic        rst;
    logic        en;
    logic        btn_left;
    logic        btn_right;
    logic        move_left_flip;
    logic        move_right_flip;
    logic        timeout_left;
    logic        timeout_right;
    logic [15:0] strokes_left;
    logic [15:0] strokes_right;

    int total = 0;
    int bad   = 0;

    flip_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .MAX_HOLD_CYCLES(MAXH),
        .COOLDOWN_CYCLES(COOL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .move_left_flip (move_left_flip),
        .move_right_flip(move_right_flip),
        .timeout_left   (timeout_left),
        .timeout_right  (timeout_right),
        .strokes_left   (strokes_left),
        .strokes_right  (strokes_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: raw sample history (index 0 = previous edge), debounced level,
    // and stroke bookkeeping in terms of elapsed hold/cooldown cycles.
    bit m_hist [2][8];
    bit m_deb  [2];
    bit m_act  [2];
    bit m_lock [2];
    int m_hold [2];
    int m_cool [2];
    bit m_tmo  [2];
    int m_str  [2];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) m_hist[s][i] = 1'b0;
            m_deb[s]  = 1'b0;
            m_act[s]  = 1'b0;
            m_lock[s] = 1'b0;
            m_hold[s] = 0;
            m_cool[s] = 0;
            m_tmo[s]  = 1'b0;
            m_str[s]  = 0;
        end
    endfunction

    function automatic void model_side(input int s, input bit raw);
        bit d;
        bit flip;
        d = m_deb[s];
        m_tmo[s] = 1'b0;
        if (m_cool[s] > 0) begin
            m_cool[s] = m_cool[s] - 1;
        end else if (m_lock[s]) begin
            if (!d && en) m_lock[s] = 1'b0;
        end else if (m_act[s]) begin
            m_hold[s] = m_hold[s] + 1;
            if (!d) begin
                m_act[s] = 1'b0;
            end else if (!en) begin
                m_act[s]  = 1'b0;
                m_lock[s] = 1'b1;
            end else if (m_hold[s] == MAXH) begin
                m_act[s]  = 1'b0;
                m_lock[s] = 1'b1;
                m_cool[s] = COOL;
                m_tmo[s]  = 1'b1;
            end
        end else if (d && en) begin
            m_act[s]  = 1'b1;
            m_hold[s] = 0;
            if (m_str[s] < 65535) m_str[s] = m_str[s] + 1;
        end
        // Debounced level flips once the synchronized level (raw two edges late)
        // has disagreed with it on D consecutive edges.
        flip = 1'b1;
        for (int i = 0; i < D; i++) begin
            if (m_hist[s][1 + i] == d) flip = 1'b0;
        end
        if (flip) m_deb[s] = !d;
        for (int i = 7; i > 0; i--) m_hist[s][i] = m_hist[s][i - 1];
        m_hist[s][0] = raw;
    endfunction

    task automatic check_outputs();
        chk_val("move_l",    32'(move_left_flip),  32'(m_act[0]));
        chk_val("move_r",    32'(move_right_flip), 32'(m_act[1]));
        chk_val("tmo_l",     32'(timeout_left),    32'(m_tmo[0]));
        chk_val("tmo_r",     32'(timeout_right),   32'(m_tmo[1]));
        chk_val("strokes_l", 32'(strokes_left),    32'(m_str[0]));
        chk_val("strokes_r", 32'(strokes_right),   32'(m_str[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            model_side(0, btn_left);
            model_side(1, btn_right);
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        tick();
        tick();
        #2;
        rst = 1'b1;
    endtask

    int hi_cnt;
    int tmo_cnt;
    int rem_l;
    int rem_r;
    int rem_en;

    initial begin
        rst       = 1'b0;
        en        = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        model_reset();
        tick();
        tick();
        #2;
        rst = 1'b1;
        en  = 1'b1;
        run(3);

        // Basic press/release latency.
        btn_left = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk_val("press_lat", 32'(move_left_flip), 32'(e == 7));
        end
        run(5);
        btn_left = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk_val("rel_lat", 32'(move_left_flip), 32'(e < 7));
        end
        chk_val("s1_strokes_l", 32'(strokes_left), 32'd1);
        chk_val("s1_strokes_r", 32'(strokes_right), 32'd0);

        // Short glitch on the right side.
        btn_right = 1'b1;
        run(3);
        btn_right = 1'b0;
        run(10);
        chk_val("glitch_strokes_r", 32'(strokes_right), 32'd0);

        // Hold through the timeout, then release and press again.
        apply_reset();
        en       = 1'b1;
        btn_left = 1'b1;
        hi_cnt   = 0;
        tmo_cnt  = 0;
        for (int e = 0; e < 60; e++) begin
            tick();
            if (move_left_flip) hi_cnt++;
            if (timeout_left) tmo_cnt++;
        end
        chk_val("hold_cycles", 32'(hi_cnt), 32'(MAXH));
        chk_val("tmo_pulses", 32'(tmo_cnt), 32'd1);
        btn_left = 1'b0;
        run(12);
        btn_left = 1'b1;
        run(7);
        chk_val("repress_move", 32'(move_left_flip), 32'd1);
        chk_val("repress_strokes", 32'(strokes_left), 32'd2);
        btn_left = 1'b0;
        run(10);

        // Both sides together, tilt mid-stroke.
        apply_reset();
        en        = 1'b1;
        btn_left  = 1'b1;
        btn_right = 1'b1;
        run(9);
        en = 1'b0;
        tick();
        chk_val("tilt_fall_l", 32'(move_left_flip), 32'd0);
        chk_val("tilt_fall_r", 32'(move_right_flip), 32'd0);
        run(3);
        en = 1'b1;
        run(8);
        chk_val("tilt_hold_r", 32'(move_right_flip), 32'd0);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        run(10);
        btn_left  = 1'b1;
        btn_right = 1'b1;
        run(7);
        chk_val("tilt_repress_r", 32'(strokes_right), 32'd2);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        run(10);

        // Asynchronous reset mid-stroke.
        apply_reset();
        en       = 1'b1;
        btn_left = 1'b1;
        run(7);
        chk_val("pre_rst_move", 32'(move_left_flip), 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk_val("async_rst_move", 32'(move_left_flip), 32'd0);
        check_outputs();
        tick();
        btn_left = 1'b0;
        #2;
        rst = 1'b1;
        run(10);
        chk_val("rst_strokes_l", 32'(strokes_left), 32'd0);

        // Tilt during cooldown; idle only after release with en high.
        apply_reset();
        en       = 1'b1;
        btn_left = 1'b1;
        run(30);
        en = 1'b0;
        run(10);
        btn_left = 1'b0;
        run(10);
        en = 1'b1;
        run(3);
        btn_left = 1'b1;
        run(8);
        chk_val("cool_repress", 32'(move_left_flip), 32'd1);
        btn_left = 1'b0;
        run(10);

        // Random traffic.
        apply_reset();
        en     = 1'b1;
        rem_l  = 1;
        rem_r  = 1;
        rem_en = 100;
        for (int c = 0; c < 4000; c++) begin
            rem_l = rem_l - 1;
            if (rem_l == 0) begin
                btn_left = !btn_left;
                rem_l    = int'($urandom_range(1, 40));
            end
            rem_r = rem_r - 1;
            if (rem_r == 0) begin
                btn_right = !btn_right;
                rem_r     = int'($urandom_range(1, 40));
            end
            rem_en = rem_en - 1;
            if (rem_en == 0) begin
                en     = !en;
                rem_en = en ? int'($urandom_range(30, 300)) : int'($urandom_range(1, 12));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flip_ctrl.md
# flip_ctrl

Per-side flipper command controller between the raw player buttons and the `flip` datapath. Synchronizes and debounces the left/right buttons, then runs one state machine per side. Each machine drives `move_left_flip`/`move_right_flip`, enforces a maximum hold time with a forced cooldown (coil protection), and counts strokes for score/debug logic. A global enable (tilt/game-over) suppresses flipper motion.

## Interface
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronized button must differ from its debounced value before the change is accepted (10 ms at 50 MHz); ≥1.
- `MAX_HOLD_CYCLES`, 100000000: maximum cycles a side stays in ACTIVE (2 s); ≥1.
- `COOLDOWN_CYCLES`, 25000000: cycles a side is forced low after a hold timeout (0.5 s); ≥1.
- `clk`  in  1  base clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  flipper enable; low = tilt/game over.
- `btn_left`  in  1  raw left button, asynchronous, active-high.
- `btn_right`  in  1  raw right button, asynchronous, active-high.
- `move_left_flip`  out  1  to `flip`; high = raise left flipper.
- `move_right_flip`  out  1  to `flip`; high = raise right flipper.
- `timeout_left`  out  1  one-cycle pulse on left ACTIVE→COOLDOWN.
- `timeout_right`  out  1  one-cycle pulse on right ACTIVE→COOLDOWN.
- `strokes_left`  out  16  left stroke count, saturating.
- `strokes_right`  out  16  right stroke count, saturating.

## Operation
- Both sides are identical and fully independent. Any combination of simultaneous events on the two sides is legal.
- Synchronizer: two flops per button.
- Debounce counter (32-bit):
  - Increments while the synchronized value differs from `deb`.
  - Clears to 0 whenever they are equal.
  - On a differing cycle with counter == DEBOUNCE_CYCLES−1: `deb` takes the synchronized value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change `deb`.
- FSM states: IDLE, ACTIVE, COOLDOWN, WAIT_RELEASE. Transitions:
  - IDLE→ACTIVE: `deb`=1 and `en`=1. The stroke counter increments here (saturates at 0xFFFF, no wrap).
  - ACTIVE→IDLE: `deb`=0.
  - ACTIVE→WAIT_RELEASE: `en`=0, with `deb`=1. If `deb`=0 and `en`=0 in the same cycle, the state goes to IDLE.
  - ACTIVE→COOLDOWN: hold counter == MAX_HOLD_CYCLES−1 while `deb`=1 and `en`=1. Release takes priority over timeout.
  - COOLDOWN→WAIT_RELEASE: phase counter == COOLDOWN_CYCLES−1. COOLDOWN ignores `en` and `deb`.
  - WAIT_RELEASE→IDLE: `deb`=0 and `en`=1.
- Phase counter (32-bit per side): cleared on every state entry and incremented each cycle in ACTIVE/COOLDOWN. ACTIVE therefore lasts at most MAX_HOLD_CYCLES cycles, and COOLDOWN lasts exactly COOLDOWN_CYCLES cycles.
- Outputs:
  - `move_*` = (state == ACTIVE), decoded from the state register only; no input→output combinational path.
  - `timeout_*` is registered, high for exactly the first cycle of COOLDOWN.
- A held button never re-fires. A new stroke always requires release then press.
- Reset (`rst`=0, asynchronous): both FSMs to IDLE; all counters, `deb`, and synchronizer flops to 0. All outputs are 0 during reset and after release. Reset mid-stroke drops `move_*` immediately, without waiting for a clock.

## Timing
- Press latency: raw button high at sampling edge k → `deb`=1 after edge k+DEBOUNCE_CYCLES+1 → `move_*`=1 after edge k+DEBOUNCE_CYCLES+2. Release latency is the same.
- Hold timeout: `move_*` is high for exactly MAX_HOLD_CYCLES cycles. `timeout_*` rises on the same edge that `move_*` falls.
- Cooldown: `move_*` stays low for at least COOLDOWN_CYCLES cycles. After that it stays low until a release/press cycle completes: debounce of the release, then debounce of the new press, plus latency.
- `en` low: `move_*` falls on the next edge. Raising `en` with the button still held does not restart the stroke.
- The stroke count updates on the same edge that `move_*` rises.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, MAX_HOLD_CYCLES=20, COOLDOWN_CYCLES=8.
- Reset, then `en`=1. Hold `btn_left` for 12 cycles, then release → `move_left_flip` rises 6 edges after the press is sampled and falls 6 edges after the release is sampled; `strokes_left`=1; the right side stays 0.
- 3-cycle pulse on `btn_right` → `move_right_flip` stays 0 and `strokes_right` stays 0.
- Hold `btn_left` for 60 cycles → `move_left_flip` high for exactly 20 cycles; `timeout_left` pulses once as it falls; `move_left_flip` stays low for the rest of the hold. After release and a new press, `move_left_flip` rises again and `strokes_left`=2.
- Both buttons pressed on the same cycle, `en` dropped mid-stroke and raised while both are still held → both `move_*` rise together, both fall one edge after `en`=0, and both stay low until released and pressed again.
- Assert `rst`=0 between clock edges while `move_left_flip`=1 → all outputs go to 0 immediately; `strokes_left`=0 after reset.
- Hold through the timeout and drop `en` during COOLDOWN → `move_left_flip` stays low for the full 8 cycles, then the FSM reaches IDLE only after release with `en`=1.
